// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer and related reset logic.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      PRST,
      WAIT,
      STABLE,
      RUN,
      FAIL
   } state_t;

   // Width needed for a counter that must hold the value n.
   function automatic int unsigned cw(input int unsigned n);
      return $unsigned($clog2(n + 1));
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer for asynchronous status inputs; clears to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL start-up sequencer: pulses the PLL reset, qualifies lock, releases the system
// reset after a stable-lock window, retries on timeout and re-sequences on lock loss.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_PULSE_CYCLES   = 16,
   parameter int unsigned LOCK_TIMEOUT       = 100000,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned LOSS_FILTER        = 4,
   parameter int unsigned MAX_RETRIES        = 3
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fail,
   output logic [3:0] retry_cnt,
   output logic [7:0] lock_loss_cnt
);

   localparam int unsigned PW = cw(RST_PULSE_CYCLES);
   localparam int unsigned TW = cw(LOCK_TIMEOUT);
   localparam int unsigned SW = cw(LOCK_STABLE_CYCLES);
   localparam int unsigned LW = cw(LOSS_FILTER);

   if (MAX_RETRIES > 15 || RST_PULSE_CYCLES < 1 || LOCK_TIMEOUT < 1 ||
       LOCK_STABLE_CYCLES < 1 || LOSS_FILTER < 1) begin : g_param_check
      $error("pll_reset_sequencer: parameter out of range");
   end

   state_t        state_q, state_d;
   logic [PW-1:0] pulse_q, pulse_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [SW-1:0] stable_q, stable_d;
   logic [LW-1:0] loss_q, loss_d;
   logic [3:0]    retry_d;
   logic [7:0]    lock_loss_d;
   logic          lk;

   sync_2ff u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lk)
   );

   // Counters idle at zero outside their own state, so every entry starts fresh.
   always_comb begin
      state_d     = state_q;
      pulse_d     = '0;
      timer_d     = '0;
      stable_d    = '0;
      loss_d      = '0;
      retry_d     = retry_cnt;
      lock_loss_d = lock_loss_cnt;

      case (state_q)
         PRST: begin
            if (pulse_q == PW'(RST_PULSE_CYCLES - 1)) state_d = WAIT;
            else                                       pulse_d = pulse_q + PW'(1);
         end
         WAIT: begin
            // Lock seen on the timeout cycle still counts as lock.
            if (lk) begin
               if (LOCK_STABLE_CYCLES <= 1) begin
                  state_d = RUN;
               end else begin
                  state_d  = STABLE;
                  stable_d = SW'(1);
               end
            end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
               if (retry_cnt == 4'(MAX_RETRIES)) begin
                  state_d = FAIL;
               end else begin
                  state_d = PRST;
                  retry_d = retry_cnt + 4'd1;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         STABLE: begin
            if (!lk)                                              state_d = WAIT;
            else if (stable_q == SW'(LOCK_STABLE_CYCLES - 1))     state_d = RUN;
            else                                                  stable_d = stable_q + SW'(1);
         end
         RUN: begin
            if (!lk) begin
               if (loss_q == LW'(LOSS_FILTER - 1)) begin
                  state_d = PRST;
                  if (lock_loss_cnt != 8'hFF) lock_loss_d = lock_loss_cnt + 8'd1;
               end else begin
                  loss_d = loss_q + LW'(1);
               end
            end
         end
         FAIL:    state_d = FAIL;
         default: state_d = PRST;
      endcase

      if (state_d == RUN && state_q != RUN) retry_d = '0;
   end

   // Outputs decode the next state so they move on the same edge as the state.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q       <= PRST;
         pulse_q       <= '0;
         timer_q       <= '0;
         stable_q      <= '0;
         loss_q        <= '0;
         retry_cnt     <= '0;
         lock_loss_cnt <= '0;
         pll_rst       <= 1'b1;
         sys_rst       <= 1'b1;
         ready         <= 1'b0;
         fail          <= 1'b0;
      end else begin
         state_q       <= state_d;
         pulse_q       <= pulse_d;
         timer_q       <= timer_d;
         stable_q      <= stable_d;
         loss_q        <= loss_d;
         retry_cnt     <= retry_d;
         lock_loss_cnt <= lock_loss_d;
         pll_rst       <= (state_d == PRST) || (state_d == FAIL);
         sys_rst       <= (state_d != RUN);
         ready         <= (state_d == RUN);
         fail          <= (state_d == FAIL);
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small parameters and hand-derived cycle timing.
module tb_pll_reset_sequencer;

   logic       refclk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [3:0] retry_cnt;
   logic [7:0] lock_loss_cnt;
   logic [3:0] ctl;
   int         vec = 0;
   int         err = 0;

   always #10 refclk = ~refclk;

   assign ctl = {pll_rst, sys_rst, ready, fail};

   pll_reset_sequencer #(
      .RST_PULSE_CYCLES   (4),
      .LOCK_TIMEOUT       (20),
      .LOCK_STABLE_CYCLES (8),
      .LOSS_FILTER        (3),
      .MAX_RETRIES        (2)
   ) dut (
      .refclk        (refclk),
      .rst           (rst),
      .pll_locked    (pll_locked),
      .pll_rst       (pll_rst),
      .sys_rst       (sys_rst),
      .ready         (ready),
      .fail          (fail),
      .retry_cnt     (retry_cnt),
      .lock_loss_cnt (lock_loss_cnt)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge refclk);
         #1;
      end
   endtask

   // Leaves the bench just after E0, the last edge that sampled rst=1.
   task automatic do_reset(input logic lock_val);
      rst        = 1'b1;
      pll_locked = lock_val;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      pll_locked = 1'b0;
      tick(3);
      vec++;
      if ({ctl, retry_cnt, lock_loss_cnt} !== {4'b1100, 4'd0, 8'd0}) begin
         err++;
         $display("FAIL reset_hold: ctl=%b retry=%0d loss=%0d, expected ctl=1100 retry=0 loss=0",
                  ctl, retry_cnt, lock_loss_cnt);
      end
      rst = 1'b0;
      tick();
      vec++;
      if (ctl !== 4'b1100) begin
         err++;
         $display("FAIL reset_first_edge: ctl=%b, expected 1100", ctl);
      end
   endtask

   task automatic test_nominal();
      do_reset(1'b0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         vec++;
         if (pll_rst !== 1'b1) begin
            err++;
            $display("FAIL nominal_prst_hold c%0d: pll_rst=%b, expected 1", i, pll_rst);
         end
      end
      tick();
      vec++;
      if (ctl !== 4'b0100) begin
         err++;
         $display("FAIL nominal_prst_end: ctl=%b, expected 0100", ctl);
      end
      tick(5);
      pll_locked = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tick();
         vec++;
         if ({sys_rst, ready} !== 2'b10) begin
            err++;
            $display("FAIL nominal_stable c%0d: sys_rst/ready=%b, expected 10", i, {sys_rst, ready});
         end
      end
      tick();
      vec++;
      if ({ctl, retry_cnt} !== {4'b0010, 4'd0}) begin
         err++;
         $display("FAIL nominal_run: ctl=%b retry=%0d, expected ctl=0010 retry=0", ctl, retry_cnt);
      end
   endtask

   task automatic test_glitch();
      tick(2);
      pll_locked = 1'b0;
      tick(2);
      pll_locked = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         vec++;
         if (ctl !== 4'b0010) begin
            err++;
            $display("FAIL glitch_short c%0d: ctl=%b, expected 0010", i, ctl);
         end
      end
      vec++;
      if (lock_loss_cnt !== 8'd0) begin
         err++;
         $display("FAIL glitch_short_count: lock_loss_cnt=%0d, expected 0", lock_loss_cnt);
      end
      pll_locked = 1'b0;
      tick(3);
      pll_locked = 1'b1;
      tick();
      vec++;
      if (ctl !== 4'b0010) begin
         err++;
         $display("FAIL glitch_long_pre: ctl=%b, expected 0010", ctl);
      end
      tick();
      vec++;
      if ({ctl, lock_loss_cnt} !== {4'b1100, 8'd1}) begin
         err++;
         $display("FAIL glitch_long_reset: ctl=%b loss=%0d, expected ctl=1100 loss=1", ctl, lock_loss_cnt);
      end
      for (int i = 1; i <= 11; i++) begin
         tick();
         vec++;
         if (ready !== 1'b0) begin
            err++;
            $display("FAIL glitch_reseq c%0d: ready=%b, expected 0", i, ready);
         end
      end
      tick();
      vec++;
      if ({ctl, lock_loss_cnt} !== {4'b0010, 8'd1}) begin
         err++;
         $display("FAIL glitch_rerun: ctl=%b loss=%0d, expected ctl=0010 loss=1", ctl, lock_loss_cnt);
      end
   endtask

   task automatic test_rst_mid_run();
      rst = 1'b1;
      tick();
      vec++;
      if ({ctl, retry_cnt, lock_loss_cnt} !== {4'b1100, 4'd0, 8'd0}) begin
         err++;
         $display("FAIL rst_mid_run: ctl=%b retry=%0d loss=%0d, expected ctl=1100 retry=0 loss=0",
                  ctl, retry_cnt, lock_loss_cnt);
      end
      rst = 1'b0;
   endtask

   task automatic test_timeout_retry();
      do_reset(1'b0);
      tick(4);
      vec++;
      if (pll_rst !== 1'b0) begin
         err++;
         $display("FAIL retry_wait_entry: pll_rst=%b, expected 0", pll_rst);
      end
      tick(19);
      vec++;
      if ({ctl, retry_cnt} !== {4'b0100, 4'd0}) begin
         err++;
         $display("FAIL retry_last_wait: ctl=%b retry=%0d, expected ctl=0100 retry=0", ctl, retry_cnt);
      end
      tick();
      vec++;
      if ({ctl, retry_cnt} !== {4'b1100, 4'd1}) begin
         err++;
         $display("FAIL retry_timeout: ctl=%b retry=%0d, expected ctl=1100 retry=1", ctl, retry_cnt);
      end
      pll_locked = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         vec++;
         if (pll_rst !== 1'b1) begin
            err++;
            $display("FAIL retry_prst_hold c%0d: pll_rst=%b, expected 1", i, pll_rst);
         end
      end
      tick();
      vec++;
      if (ctl !== 4'b0100) begin
         err++;
         $display("FAIL retry_prst_end: ctl=%b, expected 0100", ctl);
      end
      tick(7);
      vec++;
      if ({ctl, retry_cnt} !== {4'b0100, 4'd1}) begin
         err++;
         $display("FAIL retry_pre_run: ctl=%b retry=%0d, expected ctl=0100 retry=1", ctl, retry_cnt);
      end
      tick();
      vec++;
      if ({ctl, retry_cnt} !== {4'b0010, 4'd0}) begin
         err++;
         $display("FAIL retry_run_clear: ctl=%b retry=%0d, expected ctl=0010 retry=0", ctl, retry_cnt);
      end
   endtask

   task automatic test_stable_interrupt();
      do_reset(1'b0);
      tick(9);
      pll_locked = 1'b1;
      tick(5);
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tick();
         vec++;
         if ({ctl, retry_cnt} !== {4'b0100, 4'd0}) begin
            err++;
            $display("FAIL stable_restart c%0d: ctl=%b retry=%0d, expected ctl=0100 retry=0",
                     i, ctl, retry_cnt);
         end
      end
      tick();
      vec++;
      if (ctl !== 4'b0010) begin
         err++;
         $display("FAIL stable_restart_run: ctl=%b, expected 0010", ctl);
      end
   endtask

   task automatic test_rst_mid_stable();
      do_reset(1'b0);
      tick(9);
      pll_locked = 1'b1;
      tick(5);
      vec++;
      if (ctl !== 4'b0100) begin
         err++;
         $display("FAIL mid_stable_pre: ctl=%b, expected 0100", ctl);
      end
      rst = 1'b1;
      tick();
      vec++;
      if ({ctl, retry_cnt, lock_loss_cnt} !== {4'b1100, 4'd0, 8'd0}) begin
         err++;
         $display("FAIL rst_mid_stable: ctl=%b retry=%0d loss=%0d, expected ctl=1100 retry=0 loss=0",
                  ctl, retry_cnt, lock_loss_cnt);
      end
      rst = 1'b0;
      tick();
      vec++;
      if (ctl !== 4'b1100) begin
         err++;
         $display("FAIL mid_stable_restart: ctl=%b, expected 1100", ctl);
      end
   endtask

   task automatic test_fail();
      do_reset(1'b0);
      tick(71);
      vec++;
      if ({ctl, retry_cnt} !== {4'b0100, 4'd2}) begin
         err++;
         $display("FAIL fail_pre: ctl=%b retry=%0d, expected ctl=0100 retry=2", ctl, retry_cnt);
      end
      tick();
      vec++;
      if ({ctl, retry_cnt} !== {4'b1101, 4'd2}) begin
         err++;
         $display("FAIL fail_entry: ctl=%b retry=%0d, expected ctl=1101 retry=2", ctl, retry_cnt);
      end
      pll_locked = 1'b1;
      for (int i = 1; i <= 1000; i++) begin
         tick();
         vec++;
         if ({ctl, retry_cnt} !== {4'b1101, 4'd2}) begin
            err++;
            $display("FAIL fail_hold c%0d: ctl=%b retry=%0d, expected ctl=1101 retry=2", i, ctl, retry_cnt);
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vec++;
      if ({ctl, retry_cnt, lock_loss_cnt} !== {4'b1100, 4'd0, 8'd0}) begin
         err++;
         $display("FAIL fail_exit: ctl=%b retry=%0d loss=%0d, expected ctl=1100 retry=0 loss=0",
                  ctl, retry_cnt, lock_loss_cnt);
      end
      tick();
      vec++;
      if (ctl !== 4'b1100) begin
         err++;
         $display("FAIL fail_exit_prst: ctl=%b, expected 1100", ctl);
      end
   endtask

   initial begin
      rst        = 1'b1;
      pll_locked = 1'b0;
      test_reset();
      test_nominal();
      test_glitch();
      test_rst_mid_run();
      test_timeout_retry();
      test_stable_interrupt();
      test_rst_mid_stable();
      test_fail();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
